// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and next-PC selection for the single-cycle
// MIPS core, with boot/halt/resume/stall sequencing and a retired-fetch counter.
// PC is word addressed. Optional instruction-memory bounds check is compiled in
// with the macro PC_BOUNDS_CHECK_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic [1:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_d;
  logic [31:0]        count_d;
  logic signed [31:0] branch_off;
  logic signed [31:0] branch_tgt;
  logic [31:0]        run_tgt;
  logic [31:0]        cand_tgt;
  logic               tgt_ok;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pc_plus1   = pc + 32'd1;
  assign branch_off = signed'({{16{branch_imm[15]}}, branch_imm});
  assign branch_tgt = signed'(pc_plus1) + branch_off;

  // Redirect priority in RUN: JR, then J/JAL, then taken branch, then sequential.
  always_comb begin
    run_tgt = pc_plus1;
    if (jr_en)             run_tgt = jr_addr;
    else if (jump_en)      run_tgt = jump_target;
    else if (branch_taken) run_tgt = unsigned'(branch_tgt);
  end

  // Resume from HALT always steps past the HALT instruction.
  assign cand_tgt = (state_q == ST_HALT) ? pc_plus1 : run_tgt;

`ifdef PC_BOUNDS_CHECK_EN
  assign tgt_ok = (cand_tgt < 32'(IMEM_WORDS));
  // FAULT is only entered through a bounds violation and is left only by reset,
  // so the sticky flag is exactly "in FAULT".
  assign fault  = (state_q == ST_FAULT);
`else
  // Depth only matters to the bounds check; kept referenced for this build.
  localparam int unused_imem_words = IMEM_WORDS;
  assign tgt_ok = 1'b1;
  assign fault  = 1'b0;
`endif

  // Next-state, next-PC and counter selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    count_d = fetch_count;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          if (tgt_ok) begin
            pc_d    = cand_tgt;
            count_d = sat_inc(fetch_count);
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          if (tgt_ok) begin
            pc_d    = cand_tgt;
            count_d = sat_inc(fetch_count);
            state_d = ST_RUN;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      default: ;
    endcase
  end

  // State, PC and counter registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc          <= RESET_PC;
      fetch_count <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      fetch_count <= count_d;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT) || (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural model, per-cycle compare,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_pc_sequencer;

  localparam logic [31:0] RPC   = 32'h0000_0010;
  localparam int          WORDS = 256;

  logic        clk = 1'b0;
  logic        rst, stall, halt_req, resume, branch_taken, jump_en, jr_en;
  logic [15:0] branch_imm;
  logic [31:0] jump_target, jr_addr;
  logic [31:0] pc, pc_plus1, fetch_count;
  logic [1:0]  state;
  logic        halted, fault;
  logic        preload = 1'b0;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.RESET_PC(RPC), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch_taken(branch_taken), .branch_imm(branch_imm), .jump_en(jump_en),
    .jump_target(jump_target), .jr_en(jr_en), .jr_addr(jr_addr),
    .pc(pc), .pc_plus1(pc_plus1), .state(state), .halted(halted),
    .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Model state: mode is 0 BOOT, 1 RUN, 2 HALT, 3 FAULT.
  typedef struct packed {
    logic        vld;
    logic [1:0]  mode;
    logic [31:0] pc;
    logic [31:0] cnt;
  } mstate_t;

  mstate_t m = '0;

  function automatic logic addr_ok(input logic [31:0] a);
`ifdef PC_BOUNDS_CHECK_EN
    return a < WORDS;
`else
    return 1'b1;
`endif
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t     n;
    logic [31:0] target;
    longint      b;
    n = s;
    if (rst) begin
      n.vld = 1'b1; n.mode = 2'd0; n.pc = RPC; n.cnt = 0;
      return n;
    end
    if (s.mode == 2'd0) begin
      n.mode = 2'd1;
    end else if (s.mode == 2'd1 && halt_req) begin
      n.mode = 2'd2;
    end else if ((s.mode == 2'd1 && !stall) || (s.mode == 2'd2 && resume)) begin
      if (s.mode == 2'd2)    target = s.pc + 1;
      else if (jr_en)        target = jr_addr;
      else if (jump_en)      target = jump_target;
      else if (branch_taken) begin
        b = longint'(s.pc) + 1 + longint'($signed(branch_imm));
        target = b[31:0];
      end
      else                   target = s.pc + 1;
      if (addr_ok(target)) begin
        n.pc   = target;
        n.mode = 2'd1;
        if (s.cnt != 32'hFFFF_FFFF) n.cnt = s.cnt + 1;
      end else begin
        n.mode = 2'd3;
      end
    end
    return n;
  endfunction

  // Model advances on every clock edge; a preload pulse mirrors a forced counter.
  always @(posedge clk or posedge preload) begin
    if (preload) m <= '{vld: m.vld, mode: m.mode, pc: m.pc, cnt: 32'hFFFF_FFFE};
    else         m <= model_next(m);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Full output compare against the model, once per cycle.
  task automatic compare_all();
    if (m.vld) begin
      chk("pc", pc, m.pc);
      chk("pc_plus1", pc_plus1, m.pc + 32'd1);
      chk("state", {30'd0, state}, {30'd0, m.mode});
      chk("halted", {31'd0, halted}, {31'd0, (m.mode == 2'd2 || m.mode == 2'd3)});
      chk("fault", {31'd0, fault}, {31'd0, (m.mode == 2'd3)});
      chk("fetch_count", fetch_count, m.cnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    compare_all();
  endtask

  task automatic idle();
    stall = 0; halt_req = 0; resume = 0; branch_taken = 0; branch_imm = 0;
    jump_en = 0; jump_target = 0; jr_en = 0; jr_addr = 0;
  endtask

  initial begin
    rst = 1; idle();
    // Reset and boot
    step(); step();
    rst = 0;
    chk("boot_state", {30'd0, state}, 32'd0);
    chk("boot_pc", pc, 32'h10);
    chk("boot_count", fetch_count, 32'd0);
    step();
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_pc_hold", pc, 32'h10);
    step();
    chk("seq_pc1", pc, 32'h11);
    step();
    chk("seq_pc2", pc, 32'h12);
    chk("seq_count", fetch_count, 32'd2);

    // Redirect priority
    jr_en = 1; jr_addr = 32'h20; step();
    jr_addr = 32'h80; jump_en = 1; jump_target = 32'h40;
    branch_taken = 1; branch_imm = 16'hFFFE; step();
    chk("prio_jr", pc, 32'h80);
    jr_en = 0; jump_en = 0; step();
    chk("branch_neg", pc, 32'h7F);
    branch_taken = 0;

    // Stall versus halt
    jr_en = 1; jr_addr = 32'h30; step();
    jr_en = 0; stall = 1; jump_en = 1; jump_target = 32'h40;
    step(); step(); step();
    chk("stall_pc", pc, 32'h30);
    chk("stall_count", fetch_count, 32'd6);
    halt_req = 1; step();
    chk("halt_state", {30'd0, state}, 32'd2);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'h30);
    idle(); step();
    chk("halt_hold", pc, 32'h30);
    resume = 1; step();
    chk("resume_pc", pc, 32'h31);
    chk("resume_state", {30'd0, state}, 32'd1);
    chk("resume_count", fetch_count, 32'd7);
    resume = 0;

`ifndef PC_BOUNDS_CHECK_EN
    // Wrap-around
    jr_en = 1; jr_addr = 32'hFFFF_FFFF; step();
    chk("wrap_pre", pc, 32'hFFFF_FFFF);
    chk("wrap_p1", pc_plus1, 32'h0);
    jr_en = 0; step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_fault", {31'd0, fault}, 32'd0);
`endif

    // Counter saturation
    preload = 1; force dut.fetch_count = 32'hFFFF_FFFE;
    #1; release dut.fetch_count; preload = 0;
    step();
    chk("sat_reach", fetch_count, 32'hFFFF_FFFF);
    step();
    chk("sat_hold", fetch_count, 32'hFFFF_FFFF);

    // Reset while halted, with resume asserted
    halt_req = 1; step();
    halt_req = 0;
    chk("halt2_state", {30'd0, state}, 32'd2);
    rst = 1; resume = 1; step();
    chk("rst_halt_pc", pc, RPC);
    chk("rst_halt_state", {30'd0, state}, 32'd0);
    chk("rst_halt_count", fetch_count, 32'd0);
    rst = 0; resume = 0;

`ifdef PC_BOUNDS_CHECK_EN
    // Bounds fault
    step();
    jump_en = 1; jump_target = 32'h100; step();
    chk("bf_pc", pc, RPC);
    chk("bf_fault", {31'd0, fault}, 32'd1);
    chk("bf_state", {30'd0, state}, 32'd3);
    chk("bf_count", fetch_count, 32'd0);
    jump_en = 0; resume = 1; step();
    chk("bf_resume_ign", {30'd0, state}, 32'd3);
    resume = 0; rst = 1; step();
    chk("bf_rst_fault", {31'd0, fault}, 32'd0);
    chk("bf_rst_pc", pc, RPC);
    rst = 0;
`endif

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      stall        = ($urandom_range(0, 7) == 0);
      halt_req     = ($urandom_range(0, 19) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      jr_en        = ($urandom_range(0, 9) == 0);
      jr_addr      = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 300));
      jump_en      = ($urandom_range(0, 9) == 0);
      jump_target  = 32'($urandom_range(0, 300));
      branch_taken = ($urandom_range(0, 3) == 0);
      branch_imm   = 16'($urandom_range(0, 40)) - 16'd20;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
